// File: rtl/mult_div_unit_if.sv
// Core-side bus of the HI/LO multiply/divide unit: launch, MT* writes and the HI/LO read port.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mt_we;
  logic             mt_sel;
  logic [WIDTH-1:0] mt_data;
  logic [WIDTH-1:0] hilo_rd;
  logic             busy;
  logic             done;

  modport master (
    output start, op, src_a, src_b, mt_we, mt_sel, mt_data,
    input  hilo_rd, busy, done
  );

  modport slave (
    input  start, op, src_a, src_b, mt_we, mt_sel, mt_data,
    output hilo_rd, busy, done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO unit: shift-add multiply, restoring divide, sign fix-up in a final cycle.
// Optional macro FAST_MULT_EN: MULT/MULTU use a single-cycle multiplier and skip the RUN state.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic            clk,
  input logic            rst_n,
  mult_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               is_div_q, dz_q, neg_res_q, neg_rem_q;
  logic [WIDTH-1:0]   b_mag_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi, lo;
  logic               done_q;

  logic               signed_op, launch_fast;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes; signed ops work on |x| and correct the sign in FIX.
  assign signed_op = ~bus.op[0];
  assign a_abs = (signed_op && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign b_abs = (signed_op && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

`ifdef FAST_MULT_EN
  assign launch_fast = ~bus.op[1];
  assign prod_mag    = {{WIDTH{1'b0}}, acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, b_mag_q};
`else
  assign launch_fast = 1'b0;
  assign prod_mag    = acc;
`endif

  // acc = {partial product, remaining multiplier bits}; one multiplier bit retires per cycle.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag_q} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // acc = {partial remainder, dividend bits / quotient bits}; restore when the trial borrows.
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, b_mag_q};
  assign div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    prod_fix = neg_res_q ? -prod_mag : prod_mag;
    quo_fix  = neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b1;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = launch_fast ? FIX : RUN;
      end
      RUN:     if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_mag_q   <= '0;
      acc       <= '0;
      hi        <= '0;
      lo        <= '0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values of its peers.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt       <= '0;
            is_div_q  <= bus.op[1];
            dz_q      <= bus.op[1] && (bus.src_b == '0);
            neg_res_q <= signed_op && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            neg_rem_q <= signed_op && bus.src_a[WIDTH-1];
            if (bus.op[1]) begin
              acc     <= {{WIDTH{1'b0}}, a_abs};
              b_mag_q <= b_abs;
            end else begin
              acc     <= {{WIDTH{1'b0}}, b_abs};
              b_mag_q <= a_abs;
            end
          end else if (bus.mt_we) begin
            if (bus.mt_sel) hi <= bus.mt_data;
            else            lo <= bus.mt_data;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          acc <= is_div_q ? div_next : mul_next;
        end
        FIX: begin
          done_q <= 1'b1;
          if (is_div_q) begin
            lo <= dz_q ? '1 : quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hilo_rd = bus.mt_sel ? hi : lo;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus hand-written MT*, busy-disturb and reset sequences.
module tb_mult_div_unit;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus ();
  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  res_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.mt_sel = 1'b0;
    #1 lo = bus.hilo_rd;
    bus.mt_sel = 1'b1;
    #1 hi = bus.hilo_rd;
    bus.mt_sel = 1'b0;
  endtask

  // Launch one op, count busy cycles, then compare HI/LO against the scoreboard entry.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input string name, input bit disturb);
    int          cyc;
    res_t        e;
    logic [31:0] hi, lo;
    @(negedge clk);
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.start = 1'b1;
    sb.push_back('{hi: exp_hi, lo: exp_lo});
    @(negedge clk);
    bus.start = 1'b0;
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      if (disturb && cyc == 10) begin
        bus.start = 1'b1; bus.mt_we = 1'b1; bus.mt_sel = 1'b0; bus.mt_data = 32'h0BAD_0BAD;
        bus.op = OP_DIVU;
      end else begin
        bus.start = 1'b0; bus.mt_we = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.mt_we = 1'b0;
    check({name, " busy_cycles"}, 32'(cyc), 32'd33);
    check({name, " done"}, {31'd0, bus.done}, 32'd1);
    read_hilo(hi, lo);
    e = sb.pop_front();
    check({name, " hi"}, hi, e.hi);
    check({name, " lo"}, lo, e.lo);
    @(negedge clk);
    check({name, " done_once"}, {31'd0, bus.done}, 32'd0);
    check({name, " idle_after"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hi, lo, lo_before, hi_before;
    bit          seen_done;

    vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7"};
    vecs[2] = '{OP_MULTU, 32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB, "multu_3x7"};
    vecs[3] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min_sq"};
    vecs[4] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2"};
    vecs[5] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2"};
    vecs[6] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_100by7"};
    vecs[7] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};
    vecs[8] = '{OP_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, "divu_by0"};
    vecs[9] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_neg_by0"};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;
    bus.mt_we = 1'b0; bus.mt_sel = 1'b0; bus.mt_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    read_hilo(hi, lo);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name, 1'b0);

    // MTHI then MTLO in IDLE: only the selected register changes.
    read_hilo(hi_before, lo_before);
    @(negedge clk);
    bus.mt_we = 1'b1; bus.mt_sel = 1'b1; bus.mt_data = 32'hAAAA_5555;
    @(negedge clk);
    bus.mt_we = 1'b0;
    read_hilo(hi, lo);
    check("mthi hi", hi, 32'hAAAA_5555);
    check("mthi lo_kept", lo, lo_before);
    @(negedge clk);
    bus.mt_we = 1'b1; bus.mt_sel = 1'b0; bus.mt_data = 32'h1234_5678;
    @(negedge clk);
    bus.mt_we = 1'b0;
    read_hilo(hi, lo);
    check("mtlo lo", lo, 32'h1234_5678);
    check("mtlo hi_kept", hi, 32'hAAAA_5555);

    // start and mt_we during busy are ignored; the running op alone lands in HI/LO.
    do_op(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "busy_disturb", 1'b1);

    // Reset in the middle of a DIVU aborts it with no result and no done pulse.
    @(negedge clk);
    bus.op = OP_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort done", {31'd0, bus.done}, 32'd0);
    read_hilo(hi, lo);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check("abort no_done", {31'd0, seen_done}, 32'd0);

    do_op(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "post_reset_multu", 1'b0);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
